alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
Multi-cycle MULT/DIV sequencer that borrows the CPU's shared combinational ALU to compute 64-bit products and 32-bit quotient/remainder into HI/LO. It uses the ALU's adder (ALUFun 000000) and subtractor (000001) once per cycle, one iteration per cycle. It asserts alu_own while it drives the ALU, and the top level muxes the ALU inputs on that signal. The block sits beside the execute stage, which must stall on busy before reading HI/LO.

Parameters:
WIDTH, 32, operand width; HI/LO width; iteration count.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV
src_a  in  WIDTH  multiplicand / dividend
src_b  in  WIDTH  multiplier / divisor
busy  out  1  high from the cycle after start acceptance through DONE
done  out  1  one-cycle pulse in DONE; hi/lo valid
hi  out  WIDTH  HI register (remainder for divide)
lo  out  WIDTH  LO register (quotient for divide)
alu_own  out  1  sequencer drives the ALU this cycle
alu_a  out  WIDTH  ALU operand A
alu_b  out  WIDTH  ALU operand B
alu_fun  out  6  ALUFun code
alu_s  in  WIDTH  ALU result; combinational from alu_a/alu_b in the same cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi, lo, internal operand register, counter = 0; busy=done=alu_own=0; alu_a=alu_b=0; alu_fun=000000.
- States: IDLE -> RUN -> DONE -> IDLE. With SIGNED_MULDIV_EN, the states NEG_A and NEG_B come before RUN and NEG_LO and NEG_HI come after it.
- IDLE + start=1: hi<=0, lo<=src_a, opnd<=src_b, cnt<=0, latch op, go to RUN.
- start in any state other than IDLE is ignored. It is neither queued nor allowed to abort.
- alu_own=1 in every state except IDLE and DONE. In IDLE and DONE, alu_a/alu_b/alu_fun are driven to 0/0/000000.
- RUN, multiply (one step per cycle):
  - Drive alu_a=hi, alu_b=opnd, alu_fun=ADD; carry = (alu_s < hi), unsigned.
  - If lo[0]=1: hi<={carry, alu_s[W-1:1]}, lo<={alu_s[0], lo[W-1:1]}.
  - If lo[0]=0: hi<={0, hi[W-1:1]}, lo<={hi[0], lo[W-1:1]}.
- RUN, divide (restoring):
  - Form r={hi[W-2:0], lo[W-1]} and top=hi[W-1]. Drive alu_a=r, alu_b=opnd, alu_fun=SUB.
  - If top or (r >= opnd): hi<=alu_s, lo<={lo[W-2:0],1}.
  - Otherwise: hi<=r, lo<={lo[W-2:0],0}.
- RUN exits after cnt reaches WIDTH-1, which gives exactly WIDTH RUN cycles.
- Latency (unsigned): start accepted in cycle 0; done high in cycle WIDTH+1 (33). Back in IDLE at cycle 34, where a new start can be accepted.
- Divide by zero: no special case, the restoring result stands. lo=all-ones, hi=dividend. Same latency.
- hi/lo change every RUN cycle; they are architecturally valid only from done until the next accepted start, and hold their value while idle.
- Reset mid-operation aborts immediately with the reset values above. No done pulse is produced.

Optional Feature:
SIGNED_MULDIV_EN
- Defined: op[1]=1 selects signed operation, with fixed latency done=cycle WIDTH+5 (37) for both signed and unsigned ops.
  - For signed ops, NEG_A computes ALU 0-lo when src_a<0, and NEG_B computes 0-opnd when src_b<0. Each is a plain one-cycle pass-through otherwise.
  - NEG_LO: lo<=0-lo when the result sign (sa^sb) is set, for both multiply and divide.
  - NEG_HI, multiply: hi<=~hi+(lo_pre==0) via ALU ADD, applied when sa^sb.
  - NEG_HI, divide: hi<=0-hi, applied when sa.
  - Unsigned ops pass through all four states unchanged.
- Undefined: op[1] is ignored and MULT/DIV execute as MULTU/DIVU. The four extra states are absent and latency is 33.

Decomposition:
- Shared package alu_pkg: ALUFun constants (ALU_ADD=000000, ALU_SUB=000001, plus the existing codes), MULDIV op encodings, and the state enum.
- No sub-module is required. The iteration counter and step logic stay inline. A separate alu_owner_mux at top level selects the ALU inputs based on alu_own and is outside this block.

Test Plan:
- MULTU 7 x 6 -> done at cycle 33, hi=0x00000000, lo=0x0000002A, busy high for cycles 1-33.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. This exercises the carry path.
- DIVU 100/7 -> lo=14, hi=2. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, same latency.
- Start pulsed at cycles 5 and 20 during a busy operation -> ignored, result unaffected. rst_n low at cycle 10 of another operation -> all outputs 0 immediately, no done pulse; next start behaves normally.
- alu_fun check: 000000 on every multiply RUN cycle, 000001 on every divide RUN cycle, alu_own=0 in IDLE and DONE.
- With SIGNED_MULDIV_EN, MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Done at cycle 37.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUFun codes, MULT/DIV op encodings and the sequencer state enum.
package alu_pkg;

   localparam logic [5:0] ALU_ADD = 6'b000000;
   localparam logic [5:0] ALU_SUB = 6'b000001;
   localparam logic [5:0] ALU_AND = 6'b011000;
   localparam logic [5:0] ALU_OR  = 6'b011110;
   localparam logic [5:0] ALU_XOR = 6'b010110;
   localparam logic [5:0] ALU_NOR = 6'b010001;
   localparam logic [5:0] ALU_SLL = 6'b100000;
   localparam logic [5:0] ALU_SRL = 6'b100001;
   localparam logic [5:0] ALU_SRA = 6'b100011;

   // op[0] selects divide, op[1] selects signed
   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_DIVU  = 2'b01,
      OP_MULT  = 2'b10,
      OP_DIV   = 2'b11
   } md_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_NEG_A  = 3'd1,
      ST_NEG_B  = 3'd2,
      ST_RUN    = 3'd3,
      ST_NEG_LO = 3'd4,
      ST_NEG_HI = 3'd5,
      ST_DONE   = 3'd6
   } md_state_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request, result and borrowed-ALU signals of the MULT/DIV sequencer.
interface alu_muldiv_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             alu_own;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [5:0]       alu_fun;
   logic [WIDTH-1:0] alu_s;

   modport master (
      output start, op, src_a, src_b, alu_s,
      input  busy, done, hi, lo, alu_own, alu_a, alu_b, alu_fun
   );

   modport slave (
      input  start, op, src_a, src_b, alu_s,
      output busy, done, hi, lo, alu_own, alu_a, alu_b, alu_fun
   );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MULT/DIV into HI/LO, one shift-add / restoring-subtract step per cycle on the shared ALU.
// Optional signed support under SIGNED_MULDIV_EN (adds NEG_A/NEG_B before RUN, NEG_LO/NEG_HI after).
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_muldiv_seq_if.slave bus
);

   md_state_e        state_q;
   logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             is_div_q;
   logic             busy_q, done_q, own_q;
   logic [5:0]       fun_q;
`ifdef SIGNED_MULDIV_EN
   logic             sa_q, sb_q, lo_zero_q;
`endif

   logic [WIDTH-1:0] rem_shift;
   logic             carry, div_take, last_iter;
   logic [WIDTH-1:0] opa, opb;

   assign rem_shift = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
   assign carry     = bus.alu_s < hi_q;
   // hi[W-1] set means the shifted remainder overflowed WIDTH bits, so it exceeds any divisor
   assign div_take  = hi_q[WIDTH-1] | (rem_shift >= opnd_q);
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      opa = '0;
      opb = '0;
      case (state_q)
         ST_RUN: begin
            opa = is_div_q ? rem_shift : hi_q;
            opb = opnd_q;
         end
`ifdef SIGNED_MULDIV_EN
         ST_NEG_A, ST_NEG_LO: opb = lo_q;
         ST_NEG_B:            opb = opnd_q;
         ST_NEG_HI: begin
            if (is_div_q) begin
               opb = hi_q;
            end else begin
               // upper half of a 64-bit negate: ~hi plus the carry out of ~lo+1
               opa = ~hi_q;
               opb = {{(WIDTH-1){1'b0}}, lo_zero_q};
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         own_q     <= 1'b0;
         fun_q     <= ALU_ADD;
`ifdef SIGNED_MULDIV_EN
         sa_q      <= 1'b0;
         sb_q      <= 1'b0;
         lo_zero_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  hi_q     <= '0;
                  lo_q     <= bus.src_a;
                  opnd_q   <= bus.src_b;
                  cnt_q    <= '0;
                  is_div_q <= bus.op[0];
                  busy_q   <= 1'b1;
                  own_q    <= 1'b1;
`ifdef SIGNED_MULDIV_EN
                  sa_q     <= bus.op[1] & bus.src_a[WIDTH-1];
                  sb_q     <= bus.op[1] & bus.src_b[WIDTH-1];
                  fun_q    <= ALU_SUB;
                  state_q  <= ST_NEG_A;
`else
                  fun_q    <= bus.op[0] ? ALU_SUB : ALU_ADD;
                  state_q  <= ST_RUN;
`endif
               end
            end
`ifdef SIGNED_MULDIV_EN
            ST_NEG_A: begin
               if (sa_q) lo_q <= bus.alu_s;
               state_q <= ST_NEG_B;
            end
            ST_NEG_B: begin
               if (sb_q) opnd_q <= bus.alu_s;
               fun_q   <= is_div_q ? ALU_SUB : ALU_ADD;
               state_q <= ST_RUN;
            end
`endif
            ST_RUN: begin
               if (is_div_q) begin
                  hi_q <= div_take ? bus.alu_s : rem_shift;
                  lo_q <= {lo_q[WIDTH-2:0], div_take};
               end else if (lo_q[0]) begin
                  hi_q <= {carry, bus.alu_s[WIDTH-1:1]};
                  lo_q <= {bus.alu_s[0], lo_q[WIDTH-1:1]};
               end else begin
                  hi_q <= {1'b0, hi_q[WIDTH-1:1]};
                  lo_q <= {hi_q[0], lo_q[WIDTH-1:1]};
               end
               cnt_q <= cnt_q + 1'b1;
               if (last_iter) begin
`ifdef SIGNED_MULDIV_EN
                  fun_q   <= ALU_SUB;
                  state_q <= ST_NEG_LO;
`else
                  own_q   <= 1'b0;
                  fun_q   <= ALU_ADD;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
`endif
               end
            end
`ifdef SIGNED_MULDIV_EN
            ST_NEG_LO: begin
               lo_zero_q <= (lo_q == '0);
               if (sa_q ^ sb_q) lo_q <= bus.alu_s;
               fun_q   <= is_div_q ? ALU_SUB : ALU_ADD;
               state_q <= ST_NEG_HI;
            end
            ST_NEG_HI: begin
               // remainder follows the dividend sign; product high half follows the result sign
               if (is_div_q ? sa_q : (sa_q ^ sb_q)) hi_q <= bus.alu_s;
               own_q   <= 1'b0;
               fun_q   <= ALU_ADD;
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
`endif
            ST_DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.alu_own = own_q;
   assign bus.alu_fun = fun_q;
   assign bus.alu_a   = opa;
   assign bus.alu_b   = opb;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized and directed MULT/DIV runs against an arithmetic reference model, with timing and reset checks.
module tb_alu_muldiv_seq;
   import alu_pkg::*;

   localparam int W = 32;
`ifdef SIGNED_MULDIV_EN
   localparam int LAT    = 37;
   localparam int RUN0   = 3;
   localparam bit SGN_EN = 1'b1;
`else
   localparam int LAT    = 33;
   localparam int RUN0   = 1;
   localparam bit SGN_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   alu_muldiv_seq_if #(.WIDTH(W)) bus();

   // the shared ALU, as far as the sequencer uses it
   assign bus.alu_s = (bus.alu_fun == ALU_SUB) ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;

   alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // {hi, lo} from the arithmetic definition: magnitudes, then sign fix-up
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic        sgn, sa, sb;
      logic [31:0] ma, mb, q, r;
      logic [63:0] p;
      sgn = SGN_EN && op[1];
      sa  = sgn && a[31];
      sb  = sgn && b[31];
      ma  = sa ? 32'(0 - a) : a;
      mb  = sb ? 32'(0 - b) : b;
      if (!op[0]) begin
         p = {32'd0, ma} * {32'd0, mb};
         if (sa ^ sb) p = 64'(0 - p);
         return p;
      end
      if (mb == 0) begin
         q = 32'hFFFF_FFFF;
         r = ma;
      end else begin
         q = ma / mb;
         r = ma % mb;
      end
      if (sa ^ sb) q = 32'(0 - q);
      if (sa) r = 32'(0 - r);
      return {r, q};
   endfunction

   // Entered at a negedge with the DUT idle; returns at the negedge of the idle cycle after DONE.
   task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit inject);
      logic [63:0] exp;
      int          done_cyc = 0, pulses = 0, busy_bad = 0, own_bad = 0, fun_bad = 0, zero_bad = 0;
      logic [31:0] got_hi = '0, got_lo = '0;
      logic [63:0] idle_ctl = '1, idle_ab = '1, idle_hl = '0;
      bit          fin = 1'b0;
      exp = ref_result(op, a, b);
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      bus.start = 1'b1;
      for (int cyc = 1; cyc <= LAT + 20 && !fin; cyc++) begin
         @(negedge clk);
         if (bus.busy !== (cyc <= LAT)) busy_bad++;
         if (bus.alu_own !== (cyc < LAT)) own_bad++;
         if (cyc >= RUN0 && cyc < RUN0 + W && bus.alu_fun !== (op[0] ? ALU_SUB : ALU_ADD)) fun_bad++;
         if (bus.done === 1'b1) begin
            pulses++;
            if (done_cyc == 0) begin
               done_cyc = cyc;
               got_hi   = bus.hi;
               got_lo   = bus.lo;
               if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_fun !== ALU_ADD) zero_bad++;
            end
         end else if (done_cyc != 0 && cyc == done_cyc + 1) begin
            idle_ctl = 64'({bus.busy, bus.done, bus.alu_own, bus.alu_fun});
            idle_ab  = {bus.alu_a, bus.alu_b};
            idle_hl  = {bus.hi, bus.lo};
            fin      = 1'b1;
         end
         bus.start = inject && (cyc == 5 || cyc == 20);
         bus.op    = 2'($urandom);
         bus.src_a = $urandom;
         bus.src_b = $urandom;
      end
      bus.start = 1'b0;
      check({name, ".done_cyc"}, 64'(done_cyc), 64'(LAT));
      check({name, ".pulses"},   64'(pulses),   64'd1);
      check({name, ".busy"},     64'(busy_bad), 64'd0);
      check({name, ".own"},      64'(own_bad),  64'd0);
      check({name, ".fun"},      64'(fun_bad),  64'd0);
      check({name, ".done_alu"}, 64'(zero_bad), 64'd0);
      check({name, ".hi"},       64'(got_hi),   64'(exp[63:32]));
      check({name, ".lo"},       64'(got_lo),   64'(exp[31:0]));
      check({name, ".idle_ctl"}, idle_ctl,      64'd0);
      check({name, ".idle_ab"},  idle_ab,       64'd0);
      check({name, ".hold"},     idle_hl,       {got_hi, got_lo});
   endtask

   task automatic reset_mid_op();
      int pulses = 0, busy_seen = 0;
      bus.op    = OP_DIVU;
      bus.src_a = $urandom;
      bus.src_b = $urandom_range(1, 1000);
      bus.start = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("rst.ctl", 64'({bus.busy, bus.done, bus.alu_own, bus.alu_fun}), 64'd0);
      check("rst.ab",  {bus.alu_a, bus.alu_b}, 64'd0);
      check("rst.hl",  {bus.hi, bus.lo}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.done !== 1'b0) pulses++;
         if (bus.busy !== 1'b0) busy_seen++;
      end
      check("rst.no_done", 64'(pulses), 64'd0);
      check("rst.no_busy", 64'(busy_seen), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      bus.start = 1'b0;
      bus.op    = OP_MULTU;
      bus.src_a = '0;
      bus.src_b = '0;
      #1;
      check("reset.ctl", 64'({bus.busy, bus.done, bus.alu_own, bus.alu_fun}), 64'd0);
      check("reset.ab",  {bus.alu_a, bus.alu_b}, 64'd0);
      check("reset.hl",  {bus.hi, bus.lo}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("multu_7x6",  OP_MULTU, 32'd7, 32'd6, 1'b0);
      check("multu_7x6.const", {bus.hi, bus.lo}, 64'h0000_0000_0000_002A);
      run_op("multu_ones", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_ones.const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b1);
      check("divu_100_7.const", {bus.hi, bus.lo}, {32'd2, 32'd14});
      run_op("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 1'b0);
      check("divu_5_0.const", {bus.hi, bus.lo}, {32'd5, 32'hFFFF_FFFF});
      run_op("mult_m3x5",  OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
      run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef SIGNED_MULDIV_EN
      check("mult_m3x5.const", 64'(dut.bus.hi), 64'h0000_0000_FFFF_FFFF);
`endif

      reset_mid_op();
      run_op("after_rst", OP_MULTU, 32'd7, 32'd6, 1'b0);

      for (int i = 0; i < 12; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
         if (i == 4) ra = 32'h8000_0000;
         if (i == 5) rb = 32'hFFFF_FFFF;
         if (rb == 0) rb = 32'd1;
         run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, (i % 4) == 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule
